fir_sample_fifo: RTL and testbench
==================================

# fir_sample_fifo

Input sample buffer for the folded 8-tap FIR filter. It accepts samples from the upstream source over a valid/ready handshake and stores them in a small first-word-fall-through FIFO. It presents the head sample and a non-empty indication to the FIR control FSM, which consumes one sample per filter iteration by pulsing `shift`. The block decouples a bursty source from the filter's fixed four-cycle MAC schedule and flags protocol violations.

## Interface
Parameters:
- `DW`, 16, sample width in bits (signed, two's complement, passed through unmodified)
- `DEPTH`, 4, FIFO depth in samples; power of two, ≥ 2
- `AW`, log2(`DEPTH`), pointer width (derived, not overridden)

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous clear of FIFO contents and error flag
- `s_data`  in  DW  upstream sample
- `s_valid`  in  1  upstream sample valid
- `s_ready`  out  1  FIFO can accept a sample this cycle
- `en`  out  1  head sample available; drives FSM `en`
- `x_out`  out  DW  head sample; drives filter delay-line input
- `shift`  in  1  from FSM; pop the head sample at this edge
- `level`  out  AW+1  current occupancy, 0..DEPTH
- `empty`  out  1  level == 0
- `full`  out  1  level == DEPTH
- `err_underflow`  out  1  sticky: `shift` seen while empty

## Operation
- Storage: `DEPTH` × `DW` registers, write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy counter `level`. Pointers wrap modulo `DEPTH`.
- Push: `push = s_valid & s_ready & ~flush`. Writes `s_data` to `mem[wr_ptr]` and advances `wr_ptr`.
- `s_ready = ~full`, combinational from `level`. There is no pass-through: when full, a same-cycle pop does not enable a push.
- Pop: `pop = shift & ~empty & ~flush`. Advances `rd_ptr`. Head data is consumed by the filter on the same edge.
- Level update: push only → +1; pop only → −1; both or neither → unchanged.
- `en = ~empty`. `x_out = empty ? 0 : mem[rd_ptr]`, combinational (first-word fall-through).
- Underflow: `shift & empty & ~flush` sets `err_underflow`. Pointers and level do not change. The flag stays set until `rst` or `flush`.
- Flush has priority over push, pop, and the error set. At the edge it sets pointers = 0, level = 0, and `err_underflow` = 0. A concurrent push is discarded. Memory contents need not be cleared.
- Data is not modified: no rounding, no sign handling.

## Timing
- Reset values (asynchronous, immediate): `wr_ptr` = `rd_ptr` = 0, `level` = 0, `empty` = 1, `full` = 0, `s_ready` = 1, `en` = 0, `x_out` = 0, `err_underflow` = 0, all memory words = 0.
- Push-to-available latency is 1 cycle. A sample accepted at edge t gives `en` = 1 and `x_out` = that sample after edge t, when it is the head.
- Pop: with `shift` = 1 in the cycle ending at edge t, the next sample appears on `x_out` after edge t. If none remains, `en` drops and `x_out` = 0 after edge t.
- FSM compatibility: the FSM asserts `shift` only while `en` = 1, at most once per 4-cycle iteration. `x_out` must be stable for the whole cycle in which `shift` is high.
- Full boundary: at `level` = `DEPTH`, `s_ready` = 0, and the upstream holds `s_data`/`s_valid`. A pop at edge t raises `s_ready` after edge t. The held sample is accepted at edge t+1.
- Wrap-around: pointer rollover from `DEPTH`−1 to 0 must not disturb ordering or level.
- Reset mid-operation: all state returns to reset values immediately. Samples in flight are lost, and a push in the reset cycle is not accepted.

## Test plan
- Reset: assert `rst` mid-burst with `level` = 3 → immediately `level` = 0, `en` = 0, `x_out` = 0, `s_ready` = 1, `err_underflow` = 0.
- Basic fill: push 10, 20, 30 with `shift` = 0 → `level` = 3, `en` = 1, `x_out` = 10, `full` = 0. Push 40 → `full` = 1, `s_ready` = 0.
- Backpressure: with the FIFO full, hold `s_data` = 50 valid, then pulse `shift` once → `x_out` = 20, `level` = 3, `s_ready` = 1. 50 is accepted the next edge → `level` = 4.
- Simultaneous push/pop plus wrap: at `level` = 2, push 1..10 while popping every cycle → `level` stays 2 and the popped sequence is exactly in order with no loss across pointer wrap.
- Underflow: `shift` = 1 while empty → `err_underflow` = 1, `level` = 0, pointers unchanged. A subsequent push of 7 works normally (`x_out` = 7), and the flag stays set.
- Flush: at `level` = 3 with `err_underflow` = 1, assert `flush` together with push 99 → `level` = 0, `en` = 0, `err_underflow` = 0, 99 not stored. The next push of 5 gives `x_out` = 5.

Source files
------------

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through input sample buffer for the folded 8-tap FIR filter.
// Decouples a bursty valid/ready source from the FIR FSM's one-pop-per-iteration schedule.
module fir_sample_fifo #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          en,
    output logic [DW-1:0] x_out,
    input  logic          shift,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          err_underflow
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          err_q, err_d;
    logic          push, pop, underflow;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LEVEL_FULL);
    // No pass-through: a pop in the same cycle does not open a slot while full.
    assign s_ready = ~full;
    assign en      = ~empty;
    assign x_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;
    assign err_underflow = err_q;

    assign push      = s_valid & s_ready & ~flush;
    assign pop       = shift & ~empty & ~flush;
    assign underflow = shift & empty & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        err_d    = err_q | underflow;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the sample words are reset too, so nothing downstream can ever
    // observe X from storage; flush leaves them alone since they are unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed self-checking bench for fir_sample_fifo: fill, backpressure, wrap,
// underflow, flush and asynchronous reset with hand-computed expectations.
module tb_fir_sample_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          en;
    logic [DW-1:0] x_out;
    logic          shift;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          err_underflow;

    int checks = 0;
    int errors = 0;

    fir_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .en           (en),
        .x_out        (x_out),
        .shift        (shift),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [10] = '{40, 50, 1, 2, 3, 4, 5, 6, 7, 8};

    initial begin
        rst = 1'b1; flush = 1'b0; s_data = '0; s_valid = 1'b0; shift = 1'b0;
        #1;
        check("reset_level",   32'(level), 0);
        check("reset_empty",   32'(empty), 1);
        check("reset_full",    32'(full), 0);
        check("reset_s_ready", 32'(s_ready), 1);
        check("reset_en",      32'(en), 0);
        check("reset_x_out",   32'(x_out), 0);
        check("reset_err",     32'(err_underflow), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic fill
        s_valid = 1'b1;
        s_data = 16'd10; tick();
        check("fill1_en",    32'(en), 1);
        check("fill1_x_out", 32'(x_out), 10);
        s_data = 16'd20; tick();
        s_data = 16'd30; tick();
        s_valid = 1'b0;
        check("fill3_level", 32'(level), 3);
        check("fill3_en",    32'(en), 1);
        check("fill3_x_out", 32'(x_out), 10);
        check("fill3_full",  32'(full), 0);
        s_valid = 1'b1; s_data = 16'd40; tick();
        s_valid = 1'b0;
        check("fill4_full",    32'(full), 1);
        check("fill4_s_ready", 32'(s_ready), 0);
        check("fill4_level",   32'(level), 4);

        // Backpressure: held 50 is refused at the pop edge, accepted one edge later
        s_valid = 1'b1; s_data = 16'd50; shift = 1'b1;
        check("bp_x_out_stable", 32'(x_out), 10);
        tick();
        shift = 1'b0;
        check("bp_x_out",   32'(x_out), 20);
        check("bp_level",   32'(level), 3);
        check("bp_s_ready", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        check("bp_accept_level", 32'(level), 4);
        check("bp_accept_full",  32'(full), 1);

        // Drain to level 2: contents 40, 50
        shift = 1'b1; tick(); tick(); shift = 1'b0;
        check("drain_level", 32'(level), 2);
        check("drain_x_out", 32'(x_out), 40);

        // Simultaneous push/pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = DW'(i + 1); shift = 1'b1;
            #1;
            check($sformatf("wrap_pop%0d", i), 32'(x_out), 32'(exp_seq[i]));
            tick();
            check($sformatf("wrap_level%0d", i), 32'(level), 2);
        end
        s_valid = 1'b0; shift = 1'b0;
        check("wrap_tail_x_out", 32'(x_out), 9);
        shift = 1'b1; tick();
        check("wrap_last_x_out", 32'(x_out), 10);
        tick();
        check("drained_en",    32'(en), 0);
        check("drained_x_out", 32'(x_out), 0);
        check("drained_empty", 32'(empty), 1);

        // Underflow: shift still high while empty
        check("pre_uf_err", 32'(err_underflow), 0);
        tick();
        shift = 1'b0;
        check("uf_err",   32'(err_underflow), 1);
        check("uf_level", 32'(level), 0);
        check("uf_empty", 32'(empty), 1);
        s_valid = 1'b1; s_data = 16'd7; tick(); s_valid = 1'b0;
        check("uf_push_x_out", 32'(x_out), 7);
        check("uf_push_level", 32'(level), 1);
        check("uf_err_sticky", 32'(err_underflow), 1);

        // Flush with concurrent push of 99
        s_valid = 1'b1;
        s_data = 16'd8; tick();
        s_data = 16'd9; tick();
        check("pre_flush_level", 32'(level), 3);
        flush = 1'b1; s_data = 16'd99; tick();
        flush = 1'b0; s_valid = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_en",    32'(en), 0);
        check("flush_err",   32'(err_underflow), 0);
        check("flush_x_out", 32'(x_out), 0);
        s_valid = 1'b1; s_data = 16'd5; tick(); s_valid = 1'b0;
        check("post_flush_x_out", 32'(x_out), 5);
        check("post_flush_level", 32'(level), 1);

        // Asynchronous reset mid-burst at level 3
        s_valid = 1'b1;
        s_data = 16'd6; tick();
        s_data = 16'd11; tick();
        check("pre_rst_level", 32'(level), 3);
        s_data = 16'd12;
        #2 rst = 1'b1;
        #1;
        check("rst_level",   32'(level), 0);
        check("rst_en",      32'(en), 0);
        check("rst_x_out",   32'(x_out), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_err",     32'(err_underflow), 0);
        tick();
        check("rst_push_ignored", 32'(level), 0);
        rst = 1'b0; s_valid = 1'b0;
        s_valid = 1'b1; s_data = 16'hFFF0; tick(); s_valid = 1'b0;
        check("post_rst_x_out", 32'(x_out), 32'h0000_FFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
